pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer of the hazard unit's nop/freeze pair: turns hazard, branch-taken and memory-wait
//  requests into per-stage enable/flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Sits in the top-level pipeline, between the hazard unit, the ID-stage branch compare and
//  the MEM-stage SRAM handshake. Also keeps saturating stall/flush/wait counters and a memory timeout.
// PARAMETERS
//  CNT_W    16   width of each performance counter (saturating)
//  TIMEOUT  255  mem wait cycles before mem_timeout is raised (1..2^TO_W-1)
//  TO_W     8    width of the wait-length counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-low reset
//  nop           in   1      from hazard unit; 0 = load-use hazard (insert bubble into ID/EX)
//  freeze        in   1      from hazard unit; 1 = load-use hazard (hold PC and IF/ID)
//  branch_taken  in   1      ID-stage branch resolved taken this cycle
//  mem_req       in   1      MEM stage has a load/store in flight to SRAM
//  mem_ready     in   1      SRAM has completed the request this cycle
//  pc_en         out  1      PC register load enable
//  if_id_en      out  1      IF/ID register enable
//  if_id_flush   out  1      IF/ID loads a NOP (wins over if_id_en)
//  id_ex_en      out  1      ID/EX register enable
//  id_ex_bubble  out  1      ID/EX loads zero control (bubble)
//  ex_mem_en     out  1      EX/MEM register enable
//  mem_wb_bubble out  1      MEM/WB loads zero control (no write-back)
//  stall_cnt     out  CNT_W  hazard-stall cycles
//  flush_cnt     out  CNT_W  branch flushes
//  wait_cnt      out  CNT_W  memory-wait cycles
//  mem_timeout   out  1      sticky: a single wait reached TIMEOUT cycles
// BEHAVIOUR
//  - Decode: hz = freeze | ~nop (either line alone counts as a hazard); ms = mem_req & ~mem_ready.
//  - Stage controls are combinational from the current inputs (they take effect on the same
//    edge); strict priority order:
//    1 ms:      pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, if_id_flush=id_ex_bubble=0.
//    2 hz:      pc_en=if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1, if_id_flush=0.
//    3 branch:  all en=1, if_id_flush=1 (hazard wins; the ID branch re-evaluates next cycle).
//    4 else:    all en=1, flush/bubble=0.
//  - While ms, branch_taken and hz are ignored; ID is held, so they re-present after the wait.
//  - FSM, state register on clk/rst: RUN, WAIT.
//    RUN->WAIT when ms (wait_len<=1). WAIT stays while ms (wait_len++ saturating at TIMEOUT).
//    WAIT->RUN when !ms (wait_len<=0). The release cycle (mem_ready=1) is decoded with
//    priority 2..4 in the same cycle.
//  - mem_timeout is set on the edge where wait_len==TIMEOUT-1 && ms. It stays set until reset,
//    and the pipeline keeps waiting (no abort).
//  - Counters, updated on each rising edge and saturating at 2^CNT_W-1:
//    stall_cnt+1 on a priority-2 cycle; flush_cnt+1 on a priority-3 cycle; wait_cnt+1 on an ms cycle.
//  - Reset (async assert, any time incl. mid-WAIT): state=RUN, wait_len=0, all counters=0,
//    mem_timeout=0. The combinational outputs follow the inputs immediately.
//    With idle inputs (nop=1, freeze=0, branch_taken=0, mem_req=0) all en=1, flush/bubble=0.
//  - Latency: 0 cycles for stage controls; 1 cycle for counter and timeout visibility.
// STRUCTURE
//  - Shared pipeline package: state encoding RUN=1'b0 and WAIT=1'b1, plus the stage-control
//    bundle field order {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_bubble,ex_mem_en,mem_wb_bubble}.
//  - One sub-module, sat_counter (WIDTH param; inc and async rst inputs), instantiated 3x for
//    the counters. The priority decode and FSM stay inline.
// TESTING
//  1 reset, idle inputs 5 cyc -> all en=1, flush/bubble=0, counters 0, state RUN.
//  2 nop=0,freeze=1 for 1 cyc -> pc_en=if_id_en=0, id_ex_bubble=1, ex_mem_en=1; stall_cnt=1 next cycle.
//  3 branch_taken=1 with freeze=1 -> hazard controls only, flush_cnt unchanged.
//    Next cycle branch_taken=1 alone -> if_id_flush=1, flush_cnt=1.
//  4 mem_req=1, mem_ready=0 for 4 cyc, then ready=1 -> 4 cycles of all en=0 and mem_wb_bubble=1;
//    wait_cnt=4; RUN on the release edge.
//  5 TIMEOUT=3, mem wait of 5 cyc -> mem_timeout rises after the 3rd wait edge and stays 1 after ready.
//  6 rst low mid-WAIT (cycle 2) -> state RUN, counters 0, mem_timeout 0.
//    CNT_W=2 with 6 hazard cycles -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline control types: FSM state encoding and the per-stage control bundle.
package pipeline_stall_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Field order is fixed; MSB first.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Normal flow: every stage advances, nothing squashed.
    localparam stage_ctrl_t CTRL_RUN      = 7'b1101010;
    // Memory wait: whole pipe frozen, write-back suppressed.
    localparam stage_ctrl_t CTRL_MEM_WAIT = 7'b0000001;
    // Load-use hazard: hold PC and IF/ID, bubble into ID/EX, let EX/MEM drain.
    localparam stage_ctrl_t CTRL_HAZARD   = 7'b0001110;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/control bundle between the pipeline (hazard unit, branch compare, SRAM
// handshake) and the stall controller.
//   master: drives nop, freeze, branch_taken, mem_req, mem_ready; receives stage
//           controls, performance counters and mem_timeout.
//   slave : the stall controller.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             nop;
    logic             freeze;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_mem_en;
    logic             mem_wb_bubble;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_timeout;

    modport master (
        output nop, freeze, branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
               mem_wb_bubble, stall_cnt, flush_cnt, wait_cnt, mem_timeout
    );

    modport slave (
        input  nop, freeze, branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
               mem_wb_bubble, stall_cnt, flush_cnt, wait_cnt, mem_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
//   clk   : rising-edge clock
//   rst   : asynchronous, active-low reset (count -> 0)
//   inc   : count up by one on this edge unless already at all-ones
//   count : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns load-use hazard, branch-taken and memory-wait
// requests into per-stage enable/flush/bubble controls, and tracks saturating
// stall/flush/wait counters plus a sticky memory-wait timeout.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : slave side of pipeline_stall_ctrl_if
//         in : nop, freeze, branch_taken, mem_req, mem_ready
//         out: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
//              mem_wb_bubble (combinational, same-edge effect),
//              stall_cnt, flush_cnt, wait_cnt, mem_timeout (registered)
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus
);

    logic            hz;
    logic            ms;
    logic            stall_inc;
    logic            flush_inc;
    stage_ctrl_t     ctrl;
    state_t          state;
    logic [TO_W-1:0] wait_len;
    logic            timeout_q;

    // Either hazard line alone is treated as a load-use hazard.
    assign hz = bus.freeze | ~bus.nop;
    assign ms = bus.mem_req & ~bus.mem_ready;

    // Priority decode: memory wait > hazard > branch > normal.
    always_comb begin
        ctrl      = CTRL_RUN;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (ms) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (hz) begin
            ctrl      = CTRL_HAZARD;
            stall_inc = 1'b1;
        end else if (bus.branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            flush_inc        = 1'b1;
        end
    end

    assign bus.pc_en         = ctrl.pc_en;
    assign bus.if_id_en      = ctrl.if_id_en;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_en      = ctrl.id_ex_en;
    assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
    assign bus.ex_mem_en     = ctrl.ex_mem_en;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign bus.mem_timeout   = timeout_q;

    // RUN/WAIT tracker with wait-length measurement; timeout is sticky and
    // does not abort the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_len  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (ms && (wait_len == TO_W'(TIMEOUT - 1))) begin
                timeout_q <= 1'b1;
            end
            if (state == RUN) begin
                if (ms) begin
                    state    <= WAIT;
                    wait_len <= TO_W'(1);
                end
            end else begin
                if (ms) begin
                    if (wait_len != TO_W'(TIMEOUT)) begin
                        wait_len <= wait_len + TO_W'(1);
                    end
                end else begin
                    state    <= RUN;
                    wait_len <= '0;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ms),
        .count (bus.wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two instances (default parameters, and a narrow
// CNT_W=2 / TIMEOUT=3 variant) share the same stimulus and are checked against a
// cycle-level reference model.
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic nop, freeze, br, req, rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int m_stall [2];
    int m_flush [2];
    int m_wait  [2];
    int m_run   [2];
    bit m_to    [2];
    bit m_waiting;
    int cnt_max [2];
    int to_lim  [2];

    typedef struct packed {
        logic [15:0] stall;
        logic [15:0] flush;
        logic [15:0] waits;
        logic        to;
    } cnt_t;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(16)) if_a ();
    pipeline_stall_ctrl_if #(.CNT_W(2))  if_b ();

    assign if_a.nop = nop;  assign if_a.freeze = freeze;  assign if_a.branch_taken = br;
    assign if_a.mem_req = req;  assign if_a.mem_ready = rdy;
    assign if_b.nop = nop;  assign if_b.freeze = freeze;  assign if_b.branch_taken = br;
    assign if_b.mem_req = req;  assign if_b.mem_ready = rdy;

    pipeline_stall_ctrl #(.CNT_W(16), .TIMEOUT(255), .TO_W(8)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    pipeline_stall_ctrl #(.CNT_W(2), .TIMEOUT(3), .TO_W(8)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );

    // Expected stage controls from the current inputs.
    function automatic logic [6:0] exp_ctrl();
        bit ms, hz;
        logic pc, ifen, fl, idex, bub, exm, mwb;
        ms = req && !rdy;
        hz = freeze || !nop;
        if (ms) begin
            pc = 0; ifen = 0; fl = 0; idex = 0; bub = 0; exm = 0; mwb = 1;
        end else begin
            pc = !hz; ifen = !hz; fl = !hz && br; idex = 1; bub = hz; exm = 1; mwb = 0;
        end
        return {pc, ifen, fl, idex, bub, exm, mwb};
    endfunction

    function automatic logic [6:0] ctrl_of(input int d);
        if (d == 0)
            return {if_a.pc_en, if_a.if_id_en, if_a.if_id_flush, if_a.id_ex_en,
                    if_a.id_ex_bubble, if_a.ex_mem_en, if_a.mem_wb_bubble};
        return {if_b.pc_en, if_b.if_id_en, if_b.if_id_flush, if_b.id_ex_en,
                if_b.id_ex_bubble, if_b.ex_mem_en, if_b.mem_wb_bubble};
    endfunction

    function automatic cnt_t cnt_of(input int d);
        cnt_t c;
        if (d == 0) begin
            c.stall = if_a.stall_cnt; c.flush = if_a.flush_cnt;
            c.waits = if_a.wait_cnt;  c.to    = if_a.mem_timeout;
        end else begin
            c.stall = 16'(if_b.stall_cnt); c.flush = 16'(if_b.flush_cnt);
            c.waits = 16'(if_b.wait_cnt);  c.to    = if_b.mem_timeout;
        end
        return c;
    endfunction

    function automatic cnt_t exp_cnt(input int d);
        cnt_t c;
        c.stall = 16'(m_stall[d]); c.flush = 16'(m_flush[d]);
        c.waits = 16'(m_wait[d]);  c.to    = m_to[d];
        return c;
    endfunction

    function automatic logic [1:0] state_of();
        return {dut_a.state == WAIT, dut_b.state == WAIT};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_stall[d] = 0; m_flush[d] = 0; m_wait[d] = 0; m_run[d] = 0; m_to[d] = 0;
        end
        m_waiting = 0;
    endtask

    // One rising edge; the model advances from the inputs present at that edge.
    task automatic tick();
        bit ms, hz;
        ms = req && !rdy;
        hz = freeze || !nop;
        @(posedge clk);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (ms) begin
                    m_wait[d] = (m_wait[d] < cnt_max[d]) ? m_wait[d] + 1 : m_wait[d];
                    m_run[d]  = m_run[d] + 1;
                    if (m_run[d] >= to_lim[d]) m_to[d] = 1;
                end else begin
                    m_run[d] = 0;
                    if (hz) m_stall[d] = (m_stall[d] < cnt_max[d]) ? m_stall[d] + 1 : m_stall[d];
                    else if (br) m_flush[d] = (m_flush[d] < cnt_max[d]) ? m_flush[d] + 1 : m_flush[d];
                end
            end
            m_waiting = ms;
        end
        #1;
    endtask

    task automatic set_in(input bit n, input bit f, input bit b, input bit q, input bit r);
        nop = n; freeze = f; br = b; req = q; rdy = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(1, 0, 0, 0, 0);
        model_clear();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1, 0, 0, 0, 0);
        model_clear();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt_of(d) !== cnt_t'(0)) begin
                n_errors++; $display("FAIL reset_cnt dut%0d: got %h want 0", d, cnt_of(d));
            end
            n_checks++;
            if (ctrl_of(d) !== 7'b1101010) begin
                n_errors++; $display("FAIL reset_ctrl dut%0d: got %b want 1101010", d, ctrl_of(d));
            end
        end
        tick();
        rst = 1'b1;
        repeat (5) tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ctrl_of(d) !== 7'b1101010) begin
                n_errors++; $display("FAIL idle_ctrl dut%0d: got %b want 1101010", d, ctrl_of(d));
            end
            n_checks++;
            if (cnt_of(d) !== cnt_t'(0)) begin
                n_errors++; $display("FAIL idle_cnt dut%0d: got %h want 0", d, cnt_of(d));
            end
        end
        n_checks++;
        if (state_of() !== 2'b00) begin
            n_errors++; $display("FAIL idle_state: got %b want 00", state_of());
        end
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(0, 1, 0, 0, 0);
        n_checks++;
        if (ctrl_of(0) !== 7'b0001110) begin
            n_errors++; $display("FAIL hazard_ctrl: got %b want 0001110", ctrl_of(0));
        end
        n_checks++;
        if (ctrl_of(1) !== exp_ctrl()) begin
            n_errors++; $display("FAIL hazard_ctrl_b: got %b want %b", ctrl_of(1), exp_ctrl());
        end
        tick();
        set_in(1, 0, 0, 0, 0);
        n_checks++;
        if (if_a.stall_cnt !== 16'd1) begin
            n_errors++; $display("FAIL hazard_stall_cnt: got %0d want 1", if_a.stall_cnt);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt_of(d) !== exp_cnt(d)) begin
                n_errors++; $display("FAIL hazard_cnt dut%0d: got %h want %h", d, cnt_of(d), exp_cnt(d));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(1, 1, 1, 0, 0);
        n_checks++;
        if (ctrl_of(0) !== 7'b0001110) begin
            n_errors++; $display("FAIL branch_vs_hazard_ctrl: got %b want 0001110", ctrl_of(0));
        end
        tick();
        n_checks++;
        if (if_a.flush_cnt !== 16'd0 || if_a.stall_cnt !== 16'd1) begin
            n_errors++; $display("FAIL branch_vs_hazard_cnt: got flush=%0d stall=%0d want 0/1",
                                 if_a.flush_cnt, if_a.stall_cnt);
        end
        set_in(1, 0, 1, 0, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ctrl_of(d) !== 7'b1111010) begin
                n_errors++; $display("FAIL branch_ctrl dut%0d: got %b want 1111010", d, ctrl_of(d));
            end
        end
        tick();
        set_in(1, 0, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt_of(d) !== exp_cnt(d) || cnt_of(d).flush !== 16'd1) begin
                n_errors++; $display("FAIL branch_cnt dut%0d: got %h want %h", d, cnt_of(d), exp_cnt(d));
            end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            // Hazard and branch requests present during the wait must be ignored.
            set_in(i != 2, i == 1, i == 3, 1, 0);
            n_checks++;
            if (ctrl_of(0) !== 7'b0000001) begin
                n_errors++; $display("FAIL mem_wait_ctrl cyc%0d: got %b want 0000001", i, ctrl_of(0));
            end
            tick();
            n_checks++;
            if (state_of() !== 2'b11) begin
                n_errors++; $display("FAIL mem_wait_state cyc%0d: got %b want 11", i, state_of());
            end
        end
        set_in(1, 0, 0, 1, 1);
        n_checks++;
        if (ctrl_of(0) !== 7'b1101010) begin
            n_errors++; $display("FAIL mem_release_ctrl: got %b want 1101010", ctrl_of(0));
        end
        tick();
        n_checks++;
        if (state_of() !== 2'b00) begin
            n_errors++; $display("FAIL mem_release_state: got %b want 00", state_of());
        end
        n_checks++;
        if (if_a.wait_cnt !== 16'd4 || if_a.stall_cnt !== 16'd0 || if_a.flush_cnt !== 16'd0) begin
            n_errors++; $display("FAIL mem_wait_cnt: got wait=%0d stall=%0d flush=%0d want 4/0/0",
                                 if_a.wait_cnt, if_a.stall_cnt, if_a.flush_cnt);
        end
        n_checks++;
        if (cnt_of(1) !== exp_cnt(1)) begin
            n_errors++; $display("FAIL mem_wait_cnt_b: got %h want %h", cnt_of(1), exp_cnt(1));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 1, 0);
            tick();
            n_checks++;
            if (if_b.mem_timeout !== (i >= 2)) begin
                n_errors++; $display("FAIL timeout_rise edge%0d: got %b want %b", i + 1, if_b.mem_timeout, i >= 2);
            end
        end
        set_in(1, 0, 0, 1, 1);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (if_b.mem_timeout !== 1'b1 || if_a.mem_timeout !== 1'b0) begin
            n_errors++; $display("FAIL timeout_sticky: got b=%b a=%b want 1/0", if_b.mem_timeout, if_a.mem_timeout);
        end
        n_checks++;
        if (if_b.wait_cnt !== 2'd3 || if_a.wait_cnt !== 16'd5) begin
            n_errors++; $display("FAIL timeout_wait_cnt: got b=%0d a=%0d want 3/5", if_b.wait_cnt, if_a.wait_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_in(1, 0, 0, 1, 0);
        repeat (3) tick();
        n_checks++;
        if (if_b.mem_timeout !== 1'b1 || state_of() !== 2'b11) begin
            n_errors++; $display("FAIL pre_reset: got to=%b state=%b want 1/11", if_b.mem_timeout, state_of());
        end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (state_of() !== 2'b00) begin
            n_errors++; $display("FAIL mid_wait_reset_state: got %b want 00", state_of());
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt_of(d) !== cnt_t'(0)) begin
                n_errors++; $display("FAIL mid_wait_reset_cnt dut%0d: got %h want 0", d, cnt_of(d));
            end
            n_checks++;
            if (ctrl_of(d) !== exp_ctrl()) begin
                n_errors++; $display("FAIL mid_wait_reset_ctrl dut%0d: got %b want %b", d, ctrl_of(d), exp_ctrl());
            end
        end
        set_in(1, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (6) begin
            set_in(0, 0, 0, 0, 0);
            tick();
        end
        n_checks++;
        if (if_b.stall_cnt !== 2'd3 || if_a.stall_cnt !== 16'd6) begin
            n_errors++; $display("FAIL stall_saturate: got b=%0d a=%0d want 3/6", if_b.stall_cnt, if_a.stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
                   ($urandom % 2) == 0, ($urandom % 3) == 0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (ctrl_of(d) !== exp_ctrl()) begin
                    n_errors++; $display("FAIL rand_ctrl cyc%0d dut%0d: got %b want %b", i, d, ctrl_of(d), exp_ctrl());
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (cnt_of(d) !== exp_cnt(d)) begin
                    n_errors++; $display("FAIL rand_cnt cyc%0d dut%0d: got %h want %h", i, d, cnt_of(d), exp_cnt(d));
                end
            end
            n_checks++;
            if (state_of() !== {m_waiting, m_waiting}) begin
                n_errors++; $display("FAIL rand_state cyc%0d: got %b want %b", i, state_of(), {m_waiting, m_waiting});
            end
        end
    endtask

    initial begin
        cnt_max[0] = 65535; cnt_max[1] = 3;
        to_lim[0]  = 255;   to_lim[1]  = 3;
        test_reset();
        test_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
